// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder
// ------------------------------------------------------------------
// Slave end of the core's data bus, backed by a 64-bit-wide SRAM
// array with per-byte write strobes. A request seen in IDLE is
// captured, held in WAIT for a programmable number of cycles, and
// completed with a single-cycle RESP pulse. It serves as the
// simulation/FPGA data memory and as a stall source for the
// memory-stage delay paths.
//
// Parameters
//   LATENCY    cycles from request capture to data_ok (1..15)
//   MEM_WORDS  number of 64-bit words in the array (power of two)
//   BASE_ADDR  byte address of word 0
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   req_valid     request present, held by the requester until data_ok
//   req_addr      byte address; bits [2:0] are ignored for indexing
//   req_size      size code, captured for reference only
//   req_strobe    byte-lane write enables, all zero means read
//   req_data      lane-aligned write data
//   resp_addr_ok  request accepted, pulses together with resp_data_ok
//   resp_data_ok  one-cycle completion pulse
//   resp_data     aligned 64-bit read word, 0 for writes/out-of-range
//   resp_err      the current response was out of range
// ------------------------------------------------------------------
module dbus_sram_responder #(
  parameter int          LATENCY   = 2,
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic capture;
  logic enter_resp;

  logic [IDX_W-1:0] cap_index;
  logic             cap_in_range;
  logic [7:0]       cap_strobe;
  logic [63:0]      cap_data;
  logic [2:0]       cap_size;

  logic [63:0]      live_offset;
  logic [60:0]      live_word;
  logic             live_in_range;
  logic [IDX_W-1:0] live_index;

  logic [IDX_W-1:0] ent_index;
  logic             ent_in_range;
  logic [7:0]       ent_strobe;
  logic [63:0]      ent_data;

  logic [63:0] mem [MEM_WORDS];

  // The size code and the sub-word address bits carry no function here;
  // they are gathered into one sink so they are visibly intentional.
  logic unused_bits;
  assign unused_bits = &{1'b0, cap_size, live_offset[2:0]};

  // Decode the live request: the word index is taken from the full
  // offset so addresses below the base or past the end are rejected
  // rather than aliased onto the array.
  always_comb begin
    live_offset   = req_addr - BASE_ADDR;
    live_word     = live_offset[63:3];
    live_in_range = (req_addr >= BASE_ADDR) && (live_word < 61'(MEM_WORDS));
    live_index    = live_word[IDX_W-1:0];
  end

  // Operands used on the RESP-entry edge. With LATENCY=1 that edge is the
  // capture edge itself, so the live request is used straight from IDLE;
  // otherwise the captured copy is authoritative and later changes on the
  // bus during WAIT are ignored.
  always_comb begin
    ent_index    = cap_index;
    ent_in_range = cap_in_range;
    ent_strobe   = cap_strobe;
    ent_data     = cap_data;
    if (state == IDLE) begin
      ent_index    = live_index;
      ent_in_range = live_in_range;
      ent_strobe   = req_strobe;
      ent_data     = req_data;
    end
  end

  // Next-state logic. RESP always falls back to IDLE without looking at
  // req_valid, since the request still visible there is the one just
  // finished. Dropping req_valid in WAIT abandons the transaction.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture  = 1'b1;
          cnt_next = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
            cnt_next   = 4'd0;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_valid) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, captured request and registered response outputs. The response
  // flags are high only in the cycle after a RESP-entry edge; resp_data is
  // only reloaded on RESP entry so it holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cap_index    <= '0;
      cap_in_range <= 1'b0;
      cap_strobe   <= 8'd0;
      cap_data     <= 64'd0;
      cap_size     <= 3'd0;
      resp_addr_ok <= 1'b0;
      resp_data_ok <= 1'b0;
      resp_data    <= 64'd0;
      resp_err     <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      resp_addr_ok <= enter_resp;
      resp_data_ok <= enter_resp;
      resp_err     <= enter_resp && !ent_in_range;
      if (capture) begin
        cap_index    <= live_index;
        cap_in_range <= live_in_range;
        cap_strobe   <= req_strobe;
        cap_data     <= req_data;
        cap_size     <= req_size;
      end
      if (enter_resp) begin
        if (ent_in_range && (ent_strobe == 8'd0)) begin
          resp_data <= mem[ent_index];
        end else begin
          resp_data <= 64'd0;
        end
      end
    end
  end

  // Array write port. The array is never cleared; a write whose RESP-entry
  // edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && ent_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (ent_strobe[i]) begin
          mem[ent_index][8*i +: 8] <= ent_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder
// ------------------------------------------------------------------
// Self-checking bench for dbus_sram_responder. Three instances share
// one request bus: LATENCY=2 with the default array, and LATENCY=1
// and LATENCY=3 with a small array. Inputs are driven and outputs
// sampled on the falling clock edge. A cycle-by-cycle vector table
// drives the LATENCY=2 instance; hand-written sequences cover
// back-to-back requests, aborts and reset during a write.
// ------------------------------------------------------------------
module tb_dbus_sram_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;

  logic        aok1, dok1, err1;
  logic [63:0] data1;
  logic        aok2, dok2, err2;
  logic [63:0] data2;
  logic        aok3, dok3, err3;
  logic [63:0] data3;

  int checks;
  int errors;

  localparam logic [63:0] A0  = 64'h8000_0000;
  localparam logic [63:0] A8  = 64'h8000_0008;
  localparam logic [63:0] W1  = 64'h8000_0010;
  localparam logic [63:0] W2  = 64'h8000_0020;
  localparam logic [63:0] W3  = 64'h8000_0030;
  localparam logic [63:0] OOR = 64'h8000_8000;

  localparam logic [63:0] D1     = 64'h1122_3344_5566_7788;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BYTES  = 64'h0000_0000_ABCD_0000;
  localparam logic [63:0] MERGED = 64'hFFFF_FFFF_ABCD_FFFF;
  localparam logic [63:0] PA5    = 64'hA5A5_5A5A_0123_4567;
  localparam logic [63:0] DEAD   = 64'hDEAD_BEEF_CAFE_F00D;

  dbus_sram_responder #(.LATENCY(1), .MEM_WORDS(16)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(aok1), .resp_data_ok(dok1), .resp_data(data1), .resp_err(err1)
  );

  dbus_sram_responder #(.LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(aok2), .resp_data_ok(dok2), .resp_data(data2), .resp_err(err2)
  );

  dbus_sram_responder #(.LATENCY(3), .MEM_WORDS(16)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(aok3), .resp_data_ok(dok3), .resp_data(data3), .resp_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] a;
    logic [7:0]  s;
    logic [63:0] d;
    logic        eaok;
    logic        edok;
    logic [63:0] edata;
    logic        eerr;
  } vec_t;

  vec_t vq[$];

  task automatic addVec(input logic v, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic eaok, input logic edok,
                        input logic [63:0] edata, input logic eerr);
    vec_t r;
    r.v = v; r.a = a; r.s = s; r.d = d;
    r.eaok = eaok; r.edok = edok; r.edata = edata; r.eerr = eerr;
    vq.push_back(r);
  endtask

  // Drives one cycle's request on the falling edge; outputs sampled right
  // after reflect the state registered at the preceding rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] a,
                               input logic [7:0] s, input logic [63:0] d);
    @(negedge clk);
    req_valid  = v;
    req_addr   = a;
    req_strobe = s;
    req_data   = d;
    req_size   = 3'd3;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 64'd0;
    req_size   = 3'd0;
    req_strobe = 8'd0;
    req_data   = 64'd0;

    // Reset state of every instance.
    doReset(2);
    checkOutput("reset aok1", 64'(aok1), 64'd0);
    checkOutput("reset dok1", 64'(dok1), 64'd0);
    checkOutput("reset dok2", 64'(dok2), 64'd0);
    checkOutput("reset data2", data2, 64'd0);
    checkOutput("reset err2", 64'(err2), 64'd0);
    checkOutput("reset dok3", 64'(dok3), 64'd0);

    // LATENCY=2 cycle table: v, addr, strobe, data | aok, dok, data, err
    addVec(1, W1, 8'hFF, D1,    0, 0, 64'd0, 0);
    addVec(1, W1, 8'hFF, D1,    0, 0, 64'd0, 0);
    addVec(1, W1, 8'hFF, D1,    1, 1, 64'd0, 0);
    addVec(1, W1, 8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, W1, 8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, W1, 8'h00, 0,     1, 1, D1,    0);
    addVec(0, 0,  8'h00, 0,     0, 0, D1,    0);
    addVec(1, W2, 8'hFF, ONES,  0, 0, D1,    0);
    addVec(1, W2, 8'hFF, ONES,  0, 0, D1,    0);
    addVec(1, W2, 8'hFF, ONES,  1, 1, 64'd0, 0);
    addVec(1, W2, 8'h0C, BYTES, 0, 0, 64'd0, 0);
    addVec(1, W2, 8'h0C, BYTES, 0, 0, 64'd0, 0);
    addVec(1, W2, 8'h0C, BYTES, 1, 1, 64'd0, 0);
    addVec(1, W2, 8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, W2, 8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, W2, 8'h00, 0,     1, 1, MERGED, 0);
    addVec(1, 64'h1000, 8'h00, 0, 0, 0, MERGED, 0);
    addVec(1, 64'h1000, 8'h00, 0, 0, 0, MERGED, 0);
    addVec(1, 64'h1000, 8'h00, 0, 1, 1, 64'd0, 1);
    addVec(0, 0,  8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, A0, 8'hFF, PA5,   0, 0, 64'd0, 0);
    addVec(1, A0, 8'hFF, PA5,   0, 0, 64'd0, 0);
    addVec(1, A0, 8'hFF, PA5,   1, 1, 64'd0, 0);
    addVec(1, OOR, 8'hFF, DEAD, 0, 0, 64'd0, 0);
    addVec(1, OOR, 8'hFF, DEAD, 0, 0, 64'd0, 0);
    addVec(1, OOR, 8'hFF, DEAD, 1, 1, 64'd0, 1);
    addVec(1, A0, 8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, A0, 8'h00, 0,     0, 0, 64'd0, 0);
    addVec(1, A0, 8'h00, 0,     1, 1, PA5,   0);
    addVec(1, 64'h8000_0013, 8'h00, 0, 0, 0, PA5, 0);
    addVec(1, W2, 8'h00, 0,     0, 0, PA5,   0);
    addVec(1, W2, 8'h00, 0,     1, 1, D1,    0);
    addVec(0, 0,  8'h00, 0,     0, 0, D1,    0);

    for (int k = 0; k < vq.size(); k++) begin
      applyStimulus(vq[k].v, vq[k].a, vq[k].s, vq[k].d);
      checkOutput($sformatf("vec%0d aok", k), 64'(aok2), 64'(vq[k].eaok));
      checkOutput($sformatf("vec%0d dok", k), 64'(dok2), 64'(vq[k].edok));
      checkOutput($sformatf("vec%0d data", k), data2, vq[k].edata);
      checkOutput($sformatf("vec%0d err", k), 64'(err2), 64'(vq[k].eerr));
    end

    // LATENCY=1: load two words, then two reads with valid held high.
    doReset(1);
    applyStimulus(1, A0, 8'hFF, D1);
    checkOutput("l1 wr0 dok idle", 64'(dok1), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("l1 wr0 dok", 64'(dok1), 64'd1);
    applyStimulus(1, A8, 8'hFF, PA5);
    checkOutput("l1 wr1 dok idle", 64'(dok1), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("l1 wr1 dok", 64'(dok1), 64'd1);
    applyStimulus(1, A0, 8'h00, 0);
    checkOutput("l1 b2b c0 dok", 64'(dok1), 64'd0);
    applyStimulus(1, A0, 8'h00, 0);
    checkOutput("l1 b2b c1 dok", 64'(dok1), 64'd1);
    checkOutput("l1 b2b c1 data", data1, D1);
    applyStimulus(1, A8, 8'h00, 0);
    checkOutput("l1 b2b c2 dok", 64'(dok1), 64'd0);
    checkOutput("l1 b2b c2 aok", 64'(aok1), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("l1 b2b c3 dok", 64'(dok1), 64'd1);
    checkOutput("l1 b2b c3 aok", 64'(aok1), 64'd1);
    checkOutput("l1 b2b c3 data", data1, PA5);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("l1 b2b c4 dok", 64'(dok1), 64'd0);
    checkOutput("l1 b2b c4 data", data1, PA5);

    // LATENCY=3: known write, aborted read, aborted write, then read back.
    doReset(1);
    applyStimulus(1, A0, 8'hFF, D1);
    checkOutput("l3 wr t0 dok", 64'(dok3), 64'd0);
    applyStimulus(1, A0, 8'hFF, D1);
    checkOutput("l3 wr t1 dok", 64'(dok3), 64'd0);
    applyStimulus(1, A0, 8'hFF, D1);
    checkOutput("l3 wr t2 dok", 64'(dok3), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("l3 wr t3 dok", 64'(dok3), 64'd1);
    applyStimulus(1, A0, 8'h00, 0);
    checkOutput("l3 abort rd cap dok", 64'(dok3), 64'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'h00, 0);
      checkOutput($sformatf("l3 abort rd c%0d dok", i), 64'(dok3), 64'd0);
      checkOutput($sformatf("l3 abort rd c%0d aok", i), 64'(aok3), 64'd0);
    end
    applyStimulus(1, A0, 8'hFF, DEAD);
    applyStimulus(0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 8'h00, 0);
      checkOutput($sformatf("l3 abort wr c%0d dok", i), 64'(dok3), 64'd0);
    end
    applyStimulus(1, A0, 8'h00, 0);
    applyStimulus(1, A0, 8'h00, 0);
    applyStimulus(1, A0, 8'h00, 0);
    checkOutput("l3 rdback t2 dok", 64'(dok3), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("l3 rdback dok", 64'(dok3), 64'd1);
    checkOutput("l3 rdback data", data3, D1);

    // LATENCY=2: reset lands on the RESP-entry edge of a write.
    doReset(1);
    applyStimulus(1, W3, 8'hFF, PA5);
    applyStimulus(1, W3, 8'hFF, PA5);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("rst old wr dok", 64'(dok2), 64'd1);
    applyStimulus(1, W3, 8'h00, 0);
    applyStimulus(1, W3, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("rst old rd data", data2, PA5);
    applyStimulus(1, W3, 8'hFF, DEAD);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    checkOutput("rst mid aok", 64'(aok2), 64'd0);
    checkOutput("rst mid dok", 64'(dok2), 64'd0);
    checkOutput("rst mid data", data2, 64'd0);
    checkOutput("rst mid err", 64'(err2), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("rst after dok", 64'(dok2), 64'd0);
    applyStimulus(1, W3, 8'h00, 0);
    applyStimulus(1, W3, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("rst rdback dok", 64'(dok2), 64'd1);
    checkOutput("rst rdback data", data2, PA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
